lfsr_rng_arbiter: RTL



---
 rtl/lfsr_rng_arbiter_pkg.sv | 26 ++
 rtl/lfsr_rng_arbiter_rr_pick.sv | 33 +++
 rtl/lfsr_rng_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared types and defaults for the LFSR random-number arbiter.
// Imported by the arbiter top and its round-robin picker.
package lfsr_rng_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_MIX   = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam int MIX_CYC_DEF = 5;
  localparam int TO_CYC_DEF  = 16;

  // An LFSR never outputs 0, so a bound below 2 would leave it with no legal value.
  localparam int MIN_BOUND = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_rr_pick.sv
// Round-robin picker: first pending request at or after the pointer.
// Purely combinational; yields a one-hot grant and its index.
module lfsr_rng_arbiter_rr_pick
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Shares one LFSR random-number unit among NREQ requesters.
// Round-robin grant, shuffle/mix/stop/wait sequence, bound and hang checks.
module lfsr_rng_arbiter
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int N       = 3,
  parameter int NREQ    = 4,
  parameter int MIX_CYC = MIX_CYC_DEF,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NREQ-1:0]   i_Req,
  input  logic [NREQ*N-1:0] i_Max,
  output logic [NREQ-1:0]   o_Gnt,
  output logic [NREQ-1:0]   o_Ack,
  output logic              o_Err,
  output logic [N-1:0]      o_Num,
  output logic              o_Fault,
  output logic              o_fShuffle,
  output logic              o_fStop,
  output logic [N-1:0]      o_Max,
  input  logic              i_fRdy,
  input  logic [N-1:0]      i_Num
);

  localparam int IW = idx_w(NREQ);
  localparam int MW = $clog2(MIX_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   next_ptr;
  logic [MW-1:0]   mix_cnt;
  logic [TW-1:0]   to_cnt;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [N-1:0]    pick_max;
  logic            bad_bound;

  lfsr_rng_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req (i_Req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pick_max  = i_Max[int'(pick_idx)*N +: N];
  assign bad_bound = 32'(pick_max) < MIN_BOUND;
  assign next_ptr  = (gnt_idx == IW'(NREQ - 1)) ?
                     '0 : gnt_idx + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      mix_cnt    <= '0;
      to_cnt     <= '0;
      o_Gnt      <= '0;
      o_Ack      <= '0;
      o_Err      <= 1'b0;
      o_Num      <= '0;
      o_Fault    <= 1'b0;
      o_fShuffle <= 1'b0;
      o_fStop    <= 1'b0;
      o_Max      <= '0;
    end else begin
      o_Ack      <= '0;
      o_Err      <= 1'b0;
      o_fShuffle <= 1'b0;
      o_fStop    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|i_Req) begin
            o_Gnt   <= pick_gnt;
            gnt_idx <= pick_idx;
            o_Max   <= pick_max;
            state   <= bad_bound ? S_ERR : S_START;
          end
        end
        S_START: begin
          o_fShuffle <= 1'b1;
          mix_cnt    <= MW'(MIX_CYC);
          state      <= S_MIX;
        end
        // A stale ready from the previous number is ignored while mixing.
        S_MIX: begin
          if (mix_cnt == MW'(1)) begin
            o_fStop <= 1'b1;
            state   <= S_STOP;
          end else begin
            mix_cnt <= mix_cnt - 1'b1;
          end
        end
        S_STOP: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (i_fRdy) begin
            o_Num <= i_Num;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TO_CYC - 1)) begin
              o_Fault <= 1'b1;
              o_Gnt   <= '0;
              state   <= S_FAULT;
            end
          end
        end
        S_DONE: begin
          o_Ack <= o_Gnt;
          o_Gnt <= '0;
          ptr   <= next_ptr;
          state <= S_IDLE;
        end
        S_ERR: begin
          o_Ack <= o_Gnt;
          o_Err <= 1'b1;
          o_Num <= '0;
          o_Gnt <= '0;
          ptr   <= next_ptr;
          state <= S_IDLE;
        end
        // The LFSR cannot leave its wait without reset, so neither can we.
        S_FAULT: begin
          o_Fault <= 1'b1;
          o_Gnt   <= '0;
        end
      endcase
    end
  end

endmodule
